// File: rtl/clock_set_sequencer.sv
// Steps the digital clock's manual time-set buttons until every field matches a requested
// value. Fields go month first so that the date modulus is known before the date is set.
module clock_set_sequencer #(
  parameter int unsigned NS = 60,
  parameter int unsigned NH = 24,
  parameter int unsigned ND = 7,
  parameter int unsigned NM = 12,
  parameter int unsigned W  = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [W-1:0] tgt_min_i,
  input  logic [W-1:0] tgt_hrs_i,
  input  logic [W-1:0] tgt_day_i,
  input  logic [W-1:0] tgt_date_i,
  input  logic [W-1:0] tgt_mon_i,
  input  logic [W-1:0] cur_min_i,
  input  logic [W-1:0] cur_hrs_i,
  input  logic [W-1:0] cur_day_i,
  input  logic [W-1:0] cur_date_i,
  input  logic [W-1:0] cur_mon_i,
  output logic         timeset_o,
  output logic         minadv_o,
  output logic         hrsadv_o,
  output logic         dayadv_o,
  output logic         datadv_o,
  output logic         monadv_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic [3:0] {
    StIdle, StMonChk, StMonAdv, StDateChk, StDateAdv, StDayChk, StDayAdv,
    StHrsChk, StHrsAdv, StMinChk, StMinAdv, StDone
  } state_e;

  function automatic logic [W-1:0] month_len(input logic [W-1:0] m);
    case (m)
      W'(0), W'(2), W'(4), W'(6), W'(7), W'(9), W'(11): return W'(31);
      W'(1):                                            return W'(29);
      default:                                          return W'(30);
    endcase
  endfunction

  state_e       state_q, state_d;
  logic [W-1:0] step_q, step_d;
  logic [W-1:0] tgt_min_q, tgt_min_d, tgt_hrs_q, tgt_hrs_d, tgt_day_q, tgt_day_d;
  logic [W-1:0] tgt_date_q, tgt_date_d, tgt_mon_q, tgt_mon_d;
  logic         err_d;

  logic [W-1:0] cur_sel, tgt_sel, mod_sel, start_len;
  state_e       match_st, adv_st;
  logic         start_bad;

  assign start_len = month_len(tgt_mon_i);
  assign start_bad = (tgt_min_i >= W'(NS)) || (tgt_hrs_i >= W'(NH)) ||
                     (tgt_day_i >= W'(ND)) || (tgt_mon_i >= W'(NM));

  // Per-field operands for the shared CHK handler below.
  always_comb begin
    cur_sel  = '0;
    tgt_sel  = '0;
    mod_sel  = '0;
    match_st = StIdle;
    adv_st   = StIdle;
    case (state_q)
      StMonChk: begin
        cur_sel = cur_mon_i;  tgt_sel = tgt_mon_q;  mod_sel = W'(NM);
        match_st = StDateChk; adv_st = StMonAdv;
      end
      StDateChk: begin
        cur_sel = cur_date_i; tgt_sel = tgt_date_q; mod_sel = month_len(tgt_mon_q);
        match_st = StDayChk;  adv_st = StDateAdv;
      end
      StDayChk: begin
        cur_sel = cur_day_i;  tgt_sel = tgt_day_q;  mod_sel = W'(ND);
        match_st = StHrsChk;  adv_st = StDayAdv;
      end
      StHrsChk: begin
        cur_sel = cur_hrs_i;  tgt_sel = tgt_hrs_q;  mod_sel = W'(NH);
        match_st = StMinChk;  adv_st = StHrsAdv;
      end
      StMinChk: begin
        cur_sel = cur_min_i;  tgt_sel = tgt_min_q;  mod_sel = W'(NS);
        match_st = StDone;    adv_st = StMinAdv;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    tgt_min_d  = tgt_min_q;
    tgt_hrs_d  = tgt_hrs_q;
    tgt_day_d  = tgt_day_q;
    tgt_date_d = tgt_date_q;
    tgt_mon_d  = tgt_mon_q;
    err_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          if (start_bad) begin
            err_d = 1'b1;
          end else begin
            tgt_min_d  = tgt_min_i;
            tgt_hrs_d  = tgt_hrs_i;
            tgt_day_d  = tgt_day_i;
            tgt_mon_d  = tgt_mon_i;
            tgt_date_d = (tgt_date_i >= start_len) ? start_len - W'(1) : tgt_date_i;
            step_d     = '0;
            state_d    = StMonChk;
          end
        end
      end
      StMonChk, StDateChk, StDayChk, StHrsChk, StMinChk: begin
        if (cur_sel == tgt_sel) begin
          state_d = match_st;
          step_d  = '0;
        end else if (step_q >= mod_sel) begin
          // A full lap without a match means the clock is not following our pulses.
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          step_d  = step_q + W'(1);
          state_d = adv_st;
        end
      end
      StMonAdv:  state_d = StMonChk;
      StDateAdv: state_d = StDateChk;
      StDayAdv:  state_d = StDayChk;
      StHrsAdv:  state_d = StHrsChk;
      StMinAdv:  state_d = StMinChk;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      step_q     <= '0;
      tgt_min_q  <= '0;
      tgt_hrs_q  <= '0;
      tgt_day_q  <= '0;
      tgt_date_q <= '0;
      tgt_mon_q  <= '0;
      timeset_o  <= 1'b0;
      minadv_o   <= 1'b0;
      hrsadv_o   <= 1'b0;
      dayadv_o   <= 1'b0;
      datadv_o   <= 1'b0;
      monadv_o   <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      tgt_min_q  <= tgt_min_d;
      tgt_hrs_q  <= tgt_hrs_d;
      tgt_day_q  <= tgt_day_d;
      tgt_date_q <= tgt_date_d;
      tgt_mon_q  <= tgt_mon_d;
      // Outputs are decoded from the next state so they line up with state_q.
      timeset_o  <= !(state_d inside {StIdle, StDone});
      minadv_o   <= (state_d == StMinAdv);
      hrsadv_o   <= (state_d == StHrsAdv);
      dayadv_o   <= (state_d == StDayAdv);
      datadv_o   <= (state_d == StDateAdv);
      monadv_o   <= (state_d == StMonAdv);
      busy_o     <= (state_d != StIdle);
      done_o     <= (state_d == StDone);
      err_o      <= err_d;
    end
  end

endmodule

// File: tb/tb_clock_set_sequencer.sv
// Directed bench: a behavioural clock model answers the advance pulses, and a queue of
// expected run outcomes is checked as each sequence finishes.
module tb_clock_set_sequencer;
  localparam int W = 7;

  logic         clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0;
  logic [W-1:0] tgt_min_i, tgt_hrs_i, tgt_day_i, tgt_date_i, tgt_mon_i;
  logic [W-1:0] cur_min, cur_hrs, cur_day, cur_date, cur_mon;
  logic         timeset_o, minadv_o, hrsadv_o, dayadv_o, datadv_o, monadv_o;
  logic         busy_o, done_o, err_o;

  logic         ld = 1'b0, freeze_hrs = 1'b0;
  logic [W-1:0] set_min, set_hrs, set_day, set_date, set_mon;
  int           total = 0, bad = 0;

  always #5 clk_i = ~clk_i;

  clock_set_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .tgt_min_i(tgt_min_i), .tgt_hrs_i(tgt_hrs_i), .tgt_day_i(tgt_day_i),
    .tgt_date_i(tgt_date_i), .tgt_mon_i(tgt_mon_i),
    .cur_min_i(cur_min), .cur_hrs_i(cur_hrs), .cur_day_i(cur_day),
    .cur_date_i(cur_date), .cur_mon_i(cur_mon),
    .timeset_o(timeset_o), .minadv_o(minadv_o), .hrsadv_o(hrsadv_o),
    .dayadv_o(dayadv_o), .datadv_o(datadv_o), .monadv_o(monadv_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  function automatic logic [W-1:0] mlen(input logic [W-1:0] m);
    case (m)
      7'd0, 7'd2, 7'd4, 7'd6, 7'd7, 7'd9, 7'd11: return 7'd31;
      7'd1:                                      return 7'd29;
      default:                                   return 7'd30;
    endcase
  endfunction

  // Clock counter model: each advance pulse increments its field on the closing edge.
  always @(posedge clk_i) begin
    if (ld) begin
      cur_min <= set_min; cur_hrs <= set_hrs; cur_day <= set_day;
      cur_date <= set_date; cur_mon <= set_mon;
    end else begin
      if (minadv_o) cur_min <= (cur_min == 7'd59) ? 7'd0 : cur_min + 7'd1;
      if (hrsadv_o && !freeze_hrs) cur_hrs <= (cur_hrs == 7'd23) ? 7'd0 : cur_hrs + 7'd1;
      if (dayadv_o) cur_day <= (cur_day == 7'd6) ? 7'd0 : cur_day + 7'd1;
      if (datadv_o) cur_date <= (cur_date == mlen(cur_mon) - 7'd1) ? 7'd0 : cur_date + 7'd1;
      if (monadv_o) cur_mon <= (cur_mon == 7'd11) ? 7'd0 : cur_mon + 7'd1;
    end
  end

  typedef struct {
    int kind;  // 0 = ended without done/err, 1 = done, 2 = err
    int cyc;
    int ts;
    int flags; // {done, err, busy, timeset} in the ending cycle
    int pmon, pdate, pday, phrs, pmin;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic setup(input logic [W-1:0] cmon, cdate, cday, chrs, cmin,
                       input logic [W-1:0] tmon, tdate, tday, thrs, tmin);
    set_mon = cmon; set_date = cdate; set_day = cday; set_hrs = chrs; set_min = cmin;
    tgt_mon_i = tmon; tgt_date_i = tdate; tgt_day_i = tday; tgt_hrs_i = thrs;
    tgt_min_i = tmin;
    ld = 1'b1;
    @(posedge clk_i); #1;
    ld = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic push(input int kind, cyc, ts, flags, pmon, pdate, pday, phrs, pmin);
    exp_t e;
    e.kind = kind; e.cyc = cyc; e.ts = ts; e.flags = flags;
    e.pmon = pmon; e.pdate = pdate; e.pday = pday; e.phrs = phrs; e.pmin = pmin;
    sb.push_back(e);
  endtask

  // mode: 0 plain, 1 abort on first minadv, 2 reset on first datadv, 3 start with abort
  task automatic run(input string tag, input int mode);
    exp_t e;
    int c, kind, ts, flags, maxadv, nadv, psum;
    int p[5];
    bit fin;
    e = sb.pop_front();
    start_i = 1'b1;
    if (mode == 3) abort_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b0;
    c = 1; fin = 1'b0; kind = 3; flags = -1; ts = 0; maxadv = 0;
    for (int i = 0; i < 5; i++) p[i] = 0;
    while (!fin && c <= 200) begin
      if (done_o || err_o || !busy_o || (mode == 2 && datadv_o)) begin
        fin = 1'b1;
        kind = done_o ? 1 : (err_o ? 2 : 0);
        flags = int'({done_o, err_o, busy_o, timeset_o});
        if (mode == 2) begin
          rst_i = 1'b1;
          #1;
          chk({tag, ":async_rst"}, int'({datadv_o, timeset_o, busy_o}), 0);
          #1 rst_i = 1'b0;
        end
      end else begin
        ts += int'(timeset_o);
        p[0] += int'(monadv_o); p[1] += int'(datadv_o); p[2] += int'(dayadv_o);
        p[3] += int'(hrsadv_o); p[4] += int'(minadv_o);
        nadv = int'(monadv_o) + int'(datadv_o) + int'(dayadv_o) + int'(hrsadv_o) +
               int'(minadv_o);
        if (nadv > maxadv) maxadv = nadv;
        if (mode == 1 && minadv_o) abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        c++;
      end
    end
    if (!fin) c = -1;
    psum = e.pmon + e.pdate + e.pday + e.phrs + e.pmin;
    chk({tag, ":kind"}, kind, e.kind);
    chk({tag, ":cycle"}, c, e.cyc);
    chk({tag, ":timeset_cycles"}, ts, e.ts);
    chk({tag, ":end_flags"}, flags, e.flags);
    chk({tag, ":monadv"}, p[0], e.pmon);
    chk({tag, ":datadv"}, p[1], e.pdate);
    chk({tag, ":dayadv"}, p[2], e.pday);
    chk({tag, ":hrsadv"}, p[3], e.phrs);
    chk({tag, ":minadv"}, p[4], e.pmin);
    chk({tag, ":adv_onehot"}, maxadv, (psum > 0) ? 1 : 0);
  endtask

  initial begin
    #12;
    chk("reset_outputs", int'({timeset_o, minadv_o, hrsadv_o, dayadv_o, datadv_o,
                               monadv_o, busy_o, done_o, err_o}), 0);
    #2 rst_i = 1'b0;

    // 1: everything already matches
    setup(3, 14, 2, 9, 30, 3, 14, 2, 9, 30);
    push(1, 6, 5, 4'b1010, 0, 0, 0, 0, 0);
    run("all_match", 0);

    // 2: minute 10 -> 13
    setup(3, 14, 2, 9, 10, 3, 14, 2, 9, 13);
    push(1, 12, 11, 4'b1010, 0, 0, 0, 0, 3);
    run("min_only", 0);
    chk("min_only:cur_min", int'(cur_min), 13);

    // 3: hour wraps 22 -> 1
    setup(3, 14, 2, 22, 30, 3, 14, 2, 1, 30);
    push(1, 12, 11, 4'b1010, 0, 0, 0, 3, 0);
    run("hrs_wrap", 0);
    chk("hrs_wrap:cur_hrs", int'(cur_hrs), 1);
    chk("hrs_wrap:cur_min", int'(cur_min), 30);

    // 4: February date clamp, then an out-of-range minute
    setup(1, 0, 2, 9, 30, 1, 30, 2, 9, 30);
    push(1, 62, 61, 4'b1010, 0, 28, 0, 0, 0);
    run("date_clamp", 0);
    chk("date_clamp:cur_date", int'(cur_date), 28);
    setup(3, 14, 2, 9, 30, 3, 14, 2, 9, 60);
    push(2, 1, 0, 4'b0100, 0, 0, 0, 0, 0);
    run("bad_min", 0);

    // 5: frozen hour counter times out; abort mid minute advance; start+abort in idle
    setup(3, 14, 2, 5, 30, 3, 14, 2, 6, 30);
    freeze_hrs = 1'b1;
    push(2, 53, 52, 4'b0100, 0, 0, 0, 24, 0);
    run("hrs_timeout", 0);
    freeze_hrs = 1'b0;
    setup(3, 14, 2, 9, 10, 3, 14, 2, 9, 13);
    push(0, 7, 6, 4'b0000, 0, 0, 0, 0, 1);
    run("abort_min", 1);
    setup(3, 14, 2, 9, 30, 3, 14, 2, 9, 30);
    push(0, 1, 0, 4'b0000, 0, 0, 0, 0, 0);
    run("start_abort_idle", 3);

    // 6: reset during a date advance, then a clean restart
    setup(3, 0, 2, 9, 30, 3, 5, 2, 9, 30);
    push(0, 3, 2, 4'b0011, 0, 0, 0, 0, 0);
    run("rst_mid", 2);
    repeat (2) @(posedge clk_i);
    #1;
    push(1, 16, 15, 4'b1010, 0, 5, 0, 0, 0);
    run("after_rst", 0);
    chk("after_rst:cur_date", int'(cur_date), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
